// File: rtl/sap2_alu_pkg.sv
// ============================================================================
// sap2_alu_pkg : op codes, sequencer states and op helpers for the SAP-2 ALU
// Revision 1.0
// ============================================================================
`default_nettype none

package sap2_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_DCR = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_CMA = 4'b1101;
  localparam logic [3:0] OP_RAL = 4'b1110;
  localparam logic [3:0] OP_RAR = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_DCR,
      OP_INC, OP_XOR, OP_CMA, OP_RAL, OP_RAR: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

  // INC/DCR operate on TMP and write their result back there.
  function automatic logic op_writes_tmp(input logic [3:0] op);
    return (op == OP_INC) || (op == OP_DCR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : IDLE/LOAD/EXEC/DONE sequencer owning ACC, TMP and flags
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import sap2_alu_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] operand,
  input  logic       acc_wr,
  input  logic [7:0] acc_din,
  input  logic [7:0] alu_result,
  input  logic [1:0] alu_flags,
  output logic [7:0] accumulator,
  output logic [7:0] tmp,
  output logic [3:0] Sel,
  output logic       Eu,
  output logic [1:0] flags,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  seq_state_e state_q, state_d;
  logic [3:0] op_q,      op_d;
  logic [7:0] acc_q,     acc_d;
  logic [7:0] tmp_q,     tmp_d;
  logic [1:0] flags_q,   flags_d;
  logic [3:0] sel_q,     sel_d;
  logic       eu_q,      eu_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    tmp_d     = tmp_q;
    flags_d   = flags_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    eu_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc_wr) acc_d = acc_din;
        if (start) begin
          state_d = ST_LOAD;
          op_d    = op;
          tmp_d   = operand;
          sel_d   = op;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_EXEC;
        eu_d    = 1'b1;
      end
      ST_EXEC: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        illegal_d = !op_is_legal(op_q);
        if (op_is_legal(op_q)) begin
          if (op_writes_tmp(op_q)) tmp_d = alu_result;
          else                     acc_d = alu_result;
          // Rotates and complement leave the previous flags untouched.
          if (!op_q[3]) flags_d = alu_flags;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'b0000;
      acc_q     <= 8'h00;
      tmp_q     <= 8'h00;
      flags_q   <= 2'b00;
      sel_q     <= 4'b0000;
      eu_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      tmp_q     <= tmp_d;
      flags_q   <= flags_d;
      sel_q     <= sel_d;
      eu_q      <= eu_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign accumulator = acc_q;
  assign tmp         = tmp_q;
  assign flags       = flags_q;
  assign Sel         = sel_q;
  assign Eu          = eu_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : directed and random checks of alu_sequencer against a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  logic       CLK;
  logic       CLR;
  logic       start;
  logic [3:0] op;
  logic [7:0] operand;
  logic       acc_wr;
  logic [7:0] acc_din;
  logic [7:0] alu_result;
  logic [1:0] alu_flags;
  logic [7:0] accumulator;
  logic [7:0] tmp;
  logic [3:0] Sel;
  logic       Eu;
  logic [1:0] flags;
  logic       busy;
  logic       done;
  logic       illegal;

  int n_cmp;
  int n_err;

  logic [7:0] m_acc;
  logic [7:0] m_tmp;
  logic [1:0] m_flags;

  alu_sequencer dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .start       (start),
    .op          (op),
    .operand     (operand),
    .acc_wr      (acc_wr),
    .acc_din     (acc_din),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .accumulator (accumulator),
    .tmp         (tmp),
    .Sel         (Sel),
    .Eu          (Eu),
    .flags       (flags),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SAP-2 ALU: returns {sign, zero, result}.
  function automatic logic [9:0] alu_fn(input logic [3:0] s, input logic [7:0] a,
                                        input logic [7:0] t);
    logic [7:0] r;
    logic       ok;
    ok = 1'b1;
    case (s)
      4'd0:  r = a + t;
      4'd1:  r = a - t;
      4'd2:  r = a & t;
      4'd3:  r = a | t;
      4'd4:  r = t - 8'd1;
      4'd5:  r = t + 8'd1;
      4'd6:  r = a ^ t;
      4'd13: r = ~a;
      4'd14: r = {a[6:0], a[7]};
      4'd15: r = {a[0], a[7:1]};
      default: begin r = 8'h5A; ok = 1'b0; end
    endcase
    if (!ok) return {2'b11, 8'h5A};
    return {r[7], (r == 8'h00), r};
  endfunction

  function automatic logic is_legal(input logic [3:0] c);
    return !(c inside {4'd7, [4'd8:4'd12]});
  endfunction

  // Outside EXEC the bus carries junk so mistimed captures are visible.
  always_comb begin
    if (Eu) {alu_flags, alu_result} = alu_fn(Sel, accumulator, tmp);
    else    {alu_flags, alu_result} = {2'b11, 8'hA5};
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acc"},     accumulator,   8'h00);
    check({tag, "_tmp"},     tmp,           8'h00);
    check({tag, "_flags"},   8'(flags),     8'h00);
    check({tag, "_sel"},     8'(Sel),       8'h00);
    check({tag, "_eu"},      8'(Eu),        8'h00);
    check({tag, "_busy"},    8'(busy),      8'h00);
    check({tag, "_done"},    8'(done),      8'h00);
    check({tag, "_illegal"}, 8'(illegal),   8'h00);
  endtask

  task automatic acc_load(input logic [7:0] d);
    acc_wr  = 1'b1;
    acc_din = d;
    tick();
    acc_wr  = 1'b0;
    m_acc   = d;
    check("acc_load", accumulator, m_acc);
  endtask

  // One full operation: start cycle, LOAD, EXEC, DONE, back to IDLE.
  task automatic run_op(input logic [3:0] c, input logic [7:0] opnd,
                        input logic wr, input logic [7:0] din, input logic noise);
    logic [9:0] r;
    start   = 1'b1;
    op      = c;
    operand = opnd;
    acc_wr  = wr;
    acc_din = din;
    tick();
    start   = 1'b0;
    acc_wr  = 1'b0;
    op      = 4'($urandom);
    operand = 8'($urandom);
    acc_din = 8'($urandom);
    if (wr) m_acc = din;
    m_tmp = opnd;
    check("load_busy", 8'(busy), 8'h01);
    check("load_eu",   8'(Eu),   8'h00);
    check("load_sel",  8'(Sel),  8'(c));
    check("load_done", 8'(done), 8'h00);
    check("load_tmp",  tmp,      m_tmp);
    check("load_acc",  accumulator, m_acc);
    if (noise) begin
      start   = 1'b1;
      acc_wr  = 1'b1;
      acc_din = ~m_acc;
      operand = ~m_tmp;
    end
    tick();
    check("exec_eu",   8'(Eu),   8'h01);
    check("exec_sel",  8'(Sel),  8'(c));
    check("exec_done", 8'(done), 8'h00);
    check("exec_acc",  accumulator, m_acc);
    tick();
    start  = 1'b0;
    acc_wr = 1'b0;
    if (is_legal(c)) begin
      r = alu_fn(c, m_acc, m_tmp);
      if (c == 4'd4 || c == 4'd5) m_tmp = r[7:0];
      else                        m_acc = r[7:0];
      if (!c[3]) m_flags = r[9:8];
    end
    check("done_done",    8'(done),    8'h01);
    check("done_illegal", 8'(illegal), 8'(!is_legal(c)));
    check("done_eu",      8'(Eu),      8'h00);
    check("done_busy",    8'(busy),    8'h01);
    check("done_acc",     accumulator, m_acc);
    check("done_tmp",     tmp,         m_tmp);
    check("done_flags",   8'(flags),   8'(m_flags));
    tick();
    check("idle_done",    8'(done),    8'h00);
    check("idle_illegal", 8'(illegal), 8'h00);
    check("idle_busy",    8'(busy),    8'h00);
    check("idle_acc",     accumulator, m_acc);
    check("idle_flags",   8'(flags),   8'(m_flags));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    CLR     = 1'b1;
    start   = 1'b0;
    op      = 4'd0;
    operand = 8'h00;
    acc_wr  = 1'b0;
    acc_din = 8'h00;
    m_acc   = 8'h00;
    m_tmp   = 8'h00;
    m_flags = 2'b00;
    tick();
    tick();
    CLR = 1'b0;
    check_reset_state("rst");

    // ADD 5+5
    acc_load(8'h05);
    run_op(4'b0000, 8'h05, 1'b0, 8'h00, 1'b0);
    check("add_acc",   accumulator, 8'h0A);
    check("add_flags", 8'(flags),   8'h00);

    // SUB to negative, then AND to zero
    acc_load(8'h02);
    run_op(4'b0001, 8'h05, 1'b0, 8'h00, 1'b0);
    check("sub_acc",   accumulator, 8'hFD);
    check("sub_flags", 8'(flags),   8'h02);
    run_op(4'b0010, 8'h00, 1'b0, 8'h00, 1'b0);
    check("and_acc",   accumulator, 8'h00);
    check("and_flags", 8'(flags),   8'h01);

    // RAR and CMA keep the flags
    acc_load(8'h0A);
    run_op(4'b1111, 8'h77, 1'b0, 8'h00, 1'b0);
    check("rar_acc",   accumulator, 8'h05);
    check("rar_flags", 8'(flags),   8'h01);
    run_op(4'b1101, 8'h00, 1'b0, 8'h00, 1'b0);
    check("cma_acc",   accumulator, 8'hFA);
    check("cma_flags", 8'(flags),   8'h01);

    // INC/DCR write TMP
    acc_load(8'h33);
    run_op(4'b0101, 8'hFF, 1'b0, 8'h00, 1'b0);
    check("inc_tmp",   tmp,         8'h00);
    check("inc_flags", 8'(flags),   8'h01);
    check("inc_acc",   accumulator, 8'h33);
    run_op(4'b0100, 8'h00, 1'b0, 8'h00, 1'b0);
    check("dcr_tmp",   tmp,         8'hFF);
    check("dcr_flags", 8'(flags),   8'h02);

    // Illegal op with start/acc_wr noise while busy
    run_op(4'b1000, 8'h3C, 1'b0, 8'h00, 1'b1);
    check("ill_acc",   accumulator, 8'h33);
    check("ill_tmp",   tmp,         8'h3C);
    check("ill_flags", 8'(flags),   8'h02);

    // acc_wr and start together
    run_op(4'b0000, 8'h01, 1'b1, 8'h7F, 1'b1);
    check("wrst_acc",   accumulator, 8'h80);
    check("wrst_flags", 8'(flags),   8'h02);

    // Reset during EXEC aborts the op
    acc_load(8'h10);
    start   = 1'b1;
    op      = 4'b0000;
    operand = 8'h10;
    tick();
    start = 1'b0;
    tick();
    check("abort_in_exec", 8'(Eu), 8'h01);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    m_acc   = 8'h00;
    m_tmp   = 8'h00;
    m_flags = 2'b00;
    check_reset_state("abort");
    tick();
    check("abort_no_done", 8'(done), 8'h00);
    check("abort_idle",    8'(busy), 8'h00);
    acc_load(8'h10);
    run_op(4'b0000, 8'h10, 1'b0, 8'h00, 1'b0);
    check("post_abort_acc", accumulator, 8'h20);

    // Random ops
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) acc_load(8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
